// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Program-counter / fetch stage. Drives the ROM address from the PC register,
//   registers the returned word for decode, keeps a hardware return-address
//   stack for CALL/RET and applies execute-stage redirects with a one-bubble
//   penalty.
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   iStall              hold PC and the registered instruction
//   iJump / iCall / iRet redirect requests (priority iCall > iRet > iJump > iStall)
//   iTarget             redirect target for iJump / iCall
//   oAddress            ROM address (current PC)
//   iInstruction        ROM data for oAddress, same cycle
//   oInstruction, oPC   registered instruction and its address
//   oValid              0 = bubble
//   oStackDepth         return-address stack entries in use
//   oFault              sticky [0] overflow, [1] underflow
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           INSN_WIDTH   = 28,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               iStall,
  input  logic                               iJump,
  input  logic                               iCall,
  input  logic                               iRet,
  input  logic [ADDR_WIDTH-1:0]              iTarget,
  output logic [ADDR_WIDTH-1:0]              oAddress,
  input  logic [INSN_WIDTH-1:0]              iInstruction,
  output logic [INSN_WIDTH-1:0]              oInstruction,
  output logic [ADDR_WIDTH-1:0]              oPC,
  output logic                               oValid,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackDepth,
  output logic [1:0]                         oFault
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DW-1:0]         depth;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  logic                  stack_full;
  logic                  stack_empty;
  logic                  push;
  logic [IW-1:0]         push_idx;
  logic [IW-1:0]         pop_idx;
  logic [ADDR_WIDTH-1:0] ret_addr;

  assign oAddress    = pc;
  assign oStackDepth = depth;

  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);
  assign push_idx    = IW'(depth);
  assign pop_idx     = IW'(depth - DW'(1));
  // Return address is relative to the instruction execute is acting on (oPC),
  // not the PC, which has already moved on.
  assign ret_addr    = oPC + ADDR_WIDTH'(1);
  assign push        = (state == StRun) && iCall && !stack_full;

  // Stack storage is not reset; only the depth pointer defines validity.
  always_ff @(posedge Clock) begin
    if (push) begin
      stack[push_idx] <= ret_addr;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= StIdle;
      pc           <= RESET_VECTOR;
      oInstruction <= '0;
      oPC          <= '0;
      oValid       <= 1'b0;
      depth        <= '0;
      oFault       <= 2'b00;
    end else begin
      unique case (state)
        StIdle: begin
          state <= StRun;
        end
        StRun: begin
          if (iCall) begin
            oValid <= 1'b0;
            if (stack_full) begin
              oFault[0] <= 1'b1;
              state     <= StFault;
            end else begin
              depth <= depth + DW'(1);
              pc    <= iTarget;
            end
          end else if (iRet) begin
            oValid <= 1'b0;
            if (stack_empty) begin
              oFault[1] <= 1'b1;
              state     <= StFault;
            end else begin
              pc    <= stack[pop_idx];
              depth <= depth - DW'(1);
            end
          end else if (iJump) begin
            pc     <= iTarget;
            oValid <= 1'b0;
          end else if (!iStall) begin
            oInstruction <= iInstruction;
            oPC          <= pc;
            oValid       <= 1'b1;
            pc           <= pc + ADDR_WIDTH'(1);
          end
        end
        StFault: begin
          oValid <= 1'b0;
        end
        default: begin
          state <= StFault;
        end
      endcase
    end
  end

endmodule
